// File: rtl/pulse_scan_sequencer.sv
// Pulse-and-check scan engine: fires a programmable number of pulses at the
// comparator injector and tallies masked pattern matches, mismatches and handshake timeouts.
module pulse_scan_sequencer #(
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [7:0]       gap_bx,
    input  logic [31:0]      halfstrips_last,
    input  logic [31:0]      halfstrips_expect,
    input  logic [31:0]      active_strip_mask,
    input  logic             pulser_ready,
    output logic             fire_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulses_sent,
    output logic [ERR_W-1:0] match_cnt,
    output logic [ERR_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [31:0]      last_bad_pattern
);

    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {IDLE, FIRE, WAIT_LO, WAIT_HI, CHECK, GAP, DONE} state_t;

    state_t state_q, state_d;

    logic             fire_q, fire_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] pulsesSent_q, pulsesSent_d;
    logic [CNT_W-1:0] attempts_q, attempts_d;
    logic [ERR_W-1:0] matchCnt_q, matchCnt_d;
    logic [ERR_W-1:0] mismatchCnt_q, mismatchCnt_d;
    logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
    logic [31:0]      lastBad_q, lastBad_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic scanStart, doAbort, timedOut, patternMatch, gapLast, lastAttempt;

    function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ERR_W-1:0] satIncErr(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign scanStart    = (state_q == IDLE) && start && !abort;
    assign doAbort      = (state_q != IDLE) && abort;
    assign timedOut     = (timer_q == TMR_W'(TIMEOUT));
    assign patternMatch = (((halfstrips_last ^ halfstrips_expect) & active_strip_mask) == 32'd0);
    assign gapLast      = (gap_bx == 8'd0) || (timer_q >= TMR_W'(gap_bx - 8'd1));
    // A FIRE timeout issues no pulse, so scan length is tracked by attempts, not pulses_sent.
    assign lastAttempt  = (attempts_q == num_pulses);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (doAbort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (scanStart && (num_pulses != '0)) state_d = FIRE;
                FIRE: begin
                    if (pulser_ready)  state_d = WAIT_LO;
                    else if (timedOut) state_d = GAP;
                end
                WAIT_LO: begin
                    if (!pulser_ready) state_d = WAIT_HI;
                    else if (timedOut) state_d = GAP;
                end
                WAIT_HI: begin
                    if (pulser_ready)  state_d = CHECK;
                    else if (timedOut) state_d = GAP;
                end
                CHECK:   state_d = GAP;
                GAP:     if (gapLast) state_d = lastAttempt ? DONE : FIRE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fire_d        = 1'b0;
        done_d        = (state_d == DONE);
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        aborted_d     = aborted_q;
        pulsesSent_d  = pulsesSent_q;
        attempts_d    = attempts_q;
        matchCnt_d    = matchCnt_q;
        mismatchCnt_d = mismatchCnt_q;
        timeoutCnt_d  = timeoutCnt_q;
        lastBad_d     = lastBad_q;
        timer_d       = ((state_d != state_q) || (state_q == IDLE)) ? '0 : timer_q + 1'b1;

        if (scanStart) begin
            aborted_d     = 1'b0;
            pulsesSent_d  = '0;
            attempts_d    = '0;
            matchCnt_d    = '0;
            mismatchCnt_d = '0;
            timeoutCnt_d  = '0;
            lastBad_d     = '0;
            done_d        = (num_pulses == '0);
        end else if (doAbort) begin
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                FIRE: begin
                    if (pulser_ready) begin
                        fire_d       = 1'b1;
                        pulsesSent_d = satIncCnt(pulsesSent_q);
                        attempts_d   = satIncCnt(attempts_q);
                    end else if (timedOut) begin
                        timeoutCnt_d = satIncCnt(timeoutCnt_q);
                        attempts_d   = satIncCnt(attempts_q);
                    end
                end
                WAIT_LO: if (pulser_ready && timedOut)  timeoutCnt_d = satIncCnt(timeoutCnt_q);
                WAIT_HI: if (!pulser_ready && timedOut) timeoutCnt_d = satIncCnt(timeoutCnt_q);
                CHECK: begin
                    if (patternMatch) begin
                        matchCnt_d = satIncErr(matchCnt_q);
                    end else begin
                        mismatchCnt_d = satIncErr(mismatchCnt_q);
                        lastBad_d     = halfstrips_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            pulsesSent_q  <= '0;
            attempts_q    <= '0;
            matchCnt_q    <= '0;
            mismatchCnt_q <= '0;
            timeoutCnt_q  <= '0;
            lastBad_q     <= '0;
            timer_q       <= '0;
        end else begin
            fire_q        <= fire_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            pulsesSent_q  <= pulsesSent_d;
            attempts_q    <= attempts_d;
            matchCnt_q    <= matchCnt_d;
            mismatchCnt_q <= mismatchCnt_d;
            timeoutCnt_q  <= timeoutCnt_d;
            lastBad_q     <= lastBad_d;
            timer_q       <= timer_d;
        end
    end

    assign fire_pulse       = fire_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign pulses_sent      = pulsesSent_q;
    assign match_cnt        = matchCnt_q;
    assign mismatch_cnt     = mismatchCnt_q;
    assign timeout_cnt      = timeoutCnt_q;
    assign last_bad_pattern = lastBad_q;

endmodule
